// File: rtl/mem_access_unit_if.sv
// Data-memory bus between mem_access_unit (master) and the data memory (slave).
// Request is held for the whole access; completion is the active-low dmem_ready_n.
// Address, byte enables and write data are stable while dmem_req is high.
interface mem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready_n;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_rdata, dmem_ready_n
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_rdata, dmem_ready_n
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory sequencer: byte-lane steering, load extension, stall generation.
// Latency: start N -> dmem_req N+1 -> done N+2 at best; misaligned requests finish at N+1.
// Backpressure: stall held while waiting on dmem_ready_n; MEM_ACCESS_TIMEOUT_EN adds an abort timer.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            access_size,
  input  logic                  write_to_data_mem,
  input  logic                  load_unsigned,
  input  logic [31:0]           addr,
  input  logic [31:0]           store_data,
  mem_access_unit_if.master     dmem,
  output logic [31:0]           load_data,
  output logic                  done,
  output logic                  stall,
  output logic                  misaligned,
  output logic                  bus_error
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      state, state_nxt;
  logic        req_vld, mis_req, ready, timeout_hit;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt, ext_dat;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic [1:0]  off_q, size_q;
  logic        we_q, uns_q, mis_q;
  logic [7:0]  lb_dat;
  logic [15:0] lh_dat;

  assign req_vld = start && (access_size != 2'b11);
  assign mis_req = ((access_size == 2'b01) && addr[0]) ||
                   ((access_size == 2'b00) && (addr[1:0] != 2'b00));
  assign ready   = !dmem.dmem_ready_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_vld) state_nxt = mis_req ? S_DONE : S_WAIT;
      S_WAIT:  if (ready || timeout_hit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = store_data;
    case (access_size)
      2'b10: begin
        be_nxt    = 4'b0001 << addr[1:0];
        wdata_nxt = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_nxt    = 4'b0011 << {addr[1], 1'b0};
        wdata_nxt = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane select uses the offset captured at request time, not the live addr.
  always_comb begin
    lb_dat  = dmem.dmem_rdata[{off_q, 3'b000} +: 8];
    lh_dat  = dmem.dmem_rdata[{off_q[1], 4'b0000} +: 16];
    ext_dat = dmem.dmem_rdata;
    case (size_q)
      2'b10:   ext_dat = uns_q ? {24'd0, lb_dat} : {{24{lb_dat[7]}}, lb_dat};
      2'b01:   ext_dat = uns_q ? {16'd0, lh_dat} : {{16{lh_dat[15]}}, lh_dat};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      off_q     <= '0;
      size_q    <= '0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      mis_q     <= 1'b0;
      load_data <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_vld) begin
          mis_q <= mis_req;
          if (mis_req) begin
            if (!write_to_data_mem) load_data <= '0;
          end else begin
            addr_q  <= {addr[31:2], 2'b00};
            off_q   <= addr[1:0];
            be_q    <= be_nxt;
            wdata_q <= wdata_nxt;
            we_q    <= write_to_data_mem;
            size_q  <= access_size;
            uns_q   <= load_unsigned;
          end
        end
        S_WAIT: begin
          if (ready) begin
            if (!we_q) load_data <= ext_dat;
          end else if (timeout_hit) begin
            if (!we_q) load_data <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wait_cnt;
  logic          berr_q;

  // Counter sits at zero outside WAIT, so every WAIT entry starts from a clean count.
  assign timeout_hit = (state == S_WAIT) && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      berr_q   <= 1'b0;
    end else begin
      wait_cnt <= (state == S_WAIT) ? wait_cnt + 1'b1 : '0;
      if (state == S_WAIT)      berr_q <= timeout_hit && !ready;
      else if (state == S_IDLE) berr_q <= 1'b0;
    end
  end

  assign bus_error = (state == S_DONE) && berr_q;
`else
  assign timeout_hit = 1'b0;
  assign bus_error   = 1'b0;
`endif

  assign dmem.dmem_req   = (state == S_WAIT);
  assign dmem.dmem_we    = (state == S_WAIT) && we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;

  assign done       = (state == S_DONE);
  assign misaligned = (state == S_DONE) && mis_q;
  assign stall      = ((state == S_IDLE) && req_vld) || (state == S_WAIT);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, wait states, misalignment, reset, timeout.
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  access_size = 2'b11;
  logic        write_to_data_mem = 1'b0;
  logic        load_unsigned = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic [31:0] load_data;
  logic        done, stall, misaligned, bus_error;

  int n_cmp = 0;
  int n_bad = 0;

  // WAIT cycles with ready_n high in the long-wait test; kept below the timeout when it is built in.
`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int HIGH_CYC = 2;
`else
  localparam int HIGH_CYC = 4;
`endif

  mem_access_unit_if dmem();

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .access_size       (access_size),
    .write_to_data_mem (write_to_data_mem),
    .load_unsigned     (load_unsigned),
    .addr              (addr),
    .store_data        (store_data),
    .dmem              (dmem),
    .load_data         (load_data),
    .done              (done),
    .stall             (stall),
    .misaligned        (misaligned),
    .bus_error         (bus_error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] sz, input logic we, input logic uns,
                       input logic [31:0] a, input logic [31:0] sd);
    start = 1'b1; access_size = sz; write_to_data_mem = we;
    load_unsigned = uns; addr = a; store_data = sd;
  endtask

  task automatic test_reset();
    n_cmp++; if (dmem.dmem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req got %b want 0", dmem.dmem_req); end
    n_cmp++; if (dmem.dmem_we !== 1'b0) begin n_bad++; $display("FAIL reset_we got %b want 0", dmem.dmem_we); end
    n_cmp++; if ({dmem.dmem_addr, dmem.dmem_be, dmem.dmem_wdata} !== 68'd0) begin n_bad++; $display("FAIL reset_bus got %h/%b/%h want 0", dmem.dmem_addr, dmem.dmem_be, dmem.dmem_wdata); end
    n_cmp++; if (load_data !== 32'h0) begin n_bad++; $display("FAIL reset_load_data got %h want 0", load_data); end
    n_cmp++; if ({done, stall, misaligned, bus_error} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags got %b want 0000", {done, stall, misaligned, bus_error}); end
  endtask

  task automatic test_lb(input logic uns, input logic [31:0] a, input logic [31:0] rd,
                         input logic [3:0] exp_be, input logic [31:0] exp_ld);
    issue(2'b10, 1'b0, uns, a, 32'h0);
    dmem.dmem_rdata = rd; dmem.dmem_ready_n = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL lb_stall_start got %b want 1", stall); end
    tick(); start = 1'b0; issue(2'b11, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0); start = 1'b0;
    n_cmp++; if (dmem.dmem_req !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL lb_req got req=%b done=%b want 1/0", dmem.dmem_req, done); end
    n_cmp++; if (dmem.dmem_be !== exp_be) begin n_bad++; $display("FAIL lb_be got %b want %b", dmem.dmem_be, exp_be); end
    n_cmp++; if (dmem.dmem_addr !== {a[31:2], 2'b00} || dmem.dmem_we !== 1'b0) begin n_bad++; $display("FAIL lb_addr got %h we=%b want %h we=0", dmem.dmem_addr, dmem.dmem_we, {a[31:2], 2'b00}); end
    dmem.dmem_ready_n = 1'b0;
    tick();
    dmem.dmem_ready_n = 1'b1;
    n_cmp++; if (done !== 1'b1 || stall !== 1'b0 || bus_error !== 1'b0 || misaligned !== 1'b0) begin n_bad++; $display("FAIL lb_done got done=%b stall=%b berr=%b mis=%b want 1000", done, stall, bus_error, misaligned); end
    n_cmp++; if (load_data !== exp_ld) begin n_bad++; $display("FAIL lb_load_data got %h want %h", load_data, exp_ld); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL lb_done_pulse got %b want 0", done); end
  endtask

  task automatic test_sh();
    logic [31:0] prev;
    prev = load_data;
    issue(2'b01, 1'b1, 1'b0, 32'h202, 32'h1234_ABCD);
    dmem.dmem_rdata = 32'h5555_5555; dmem.dmem_ready_n = 1'b1;
    tick(); start = 1'b0;
    n_cmp++; if (dmem.dmem_addr !== 32'h200) begin n_bad++; $display("FAIL sh_addr got %h want 00000200", dmem.dmem_addr); end
    n_cmp++; if (dmem.dmem_be !== 4'b1100) begin n_bad++; $display("FAIL sh_be got %b want 1100", dmem.dmem_be); end
    n_cmp++; if (dmem.dmem_wdata !== 32'hABCD_ABCD) begin n_bad++; $display("FAIL sh_wdata got %h want abcdabcd", dmem.dmem_wdata); end
    n_cmp++; if (dmem.dmem_we !== 1'b1 || dmem.dmem_req !== 1'b1) begin n_bad++; $display("FAIL sh_we got we=%b req=%b want 1/1", dmem.dmem_we, dmem.dmem_req); end
    dmem.dmem_ready_n = 1'b0;
    tick();
    dmem.dmem_ready_n = 1'b1;
    n_cmp++; if (done !== 1'b1 || load_data !== prev) begin n_bad++; $display("FAIL sh_done got done=%b ld=%h want 1/%h", done, load_data, prev); end
    tick();
  endtask

  task automatic test_lw_wait();
    int stall_cnt;
    stall_cnt = 0;
    issue(2'b00, 1'b0, 1'b1, 32'h300, 32'h0);
    dmem.dmem_rdata = 32'hDEAD_BEEF; dmem.dmem_ready_n = 1'b1;
    #1; if (stall) stall_cnt++;
    tick(); start = 1'b0;
    for (int i = 0; i < HIGH_CYC; i++) begin
      if (stall) stall_cnt++;
      n_cmp++; if (dmem.dmem_req !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL lw_hold cyc%0d got req=%b done=%b want 1/0", i, dmem.dmem_req, done); end
      tick();
    end
    dmem.dmem_ready_n = 1'b0;
    #1; if (stall) stall_cnt++;
    tick();
    dmem.dmem_ready_n = 1'b1;
    n_cmp++; if (stall_cnt != HIGH_CYC + 2) begin n_bad++; $display("FAIL lw_stall_cycles got %0d want %0d", stall_cnt, HIGH_CYC + 2); end
    n_cmp++; if (done !== 1'b1 || load_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL lw_done got done=%b ld=%h want 1/deadbeef", done, load_data); end
    tick();
  endtask

  task automatic test_misaligned();
    issue(2'b00, 1'b0, 1'b0, 32'h102, 32'h0);
    dmem.dmem_ready_n = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL mis_stall got %b want 1", stall); end
    tick(); start = 1'b0;
    n_cmp++; if (done !== 1'b1 || misaligned !== 1'b1 || dmem.dmem_req !== 1'b0) begin n_bad++; $display("FAIL mis_done got done=%b mis=%b req=%b want 1/1/0", done, misaligned, dmem.dmem_req); end
    n_cmp++; if (load_data !== 32'h0) begin n_bad++; $display("FAIL mis_load_data got %h want 0", load_data); end
    dmem.dmem_ready_n = 1'b1;
    tick();
    n_cmp++; if (done !== 1'b0 || misaligned !== 1'b0 || dmem.dmem_req !== 1'b0) begin n_bad++; $display("FAIL mis_after got done=%b mis=%b req=%b want 0/0/0", done, misaligned, dmem.dmem_req); end
  endtask

  task automatic test_reset_mid_wait();
    issue(2'b10, 1'b0, 1'b0, 32'h101, 32'h0);
    dmem.dmem_ready_n = 1'b1;
    tick(); start = 1'b0;
    n_cmp++; if (dmem.dmem_req !== 1'b1) begin n_bad++; $display("FAIL rst_wait_req got %b want 1", dmem.dmem_req); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (dmem.dmem_req !== 1'b0 || stall !== 1'b0) begin n_bad++; $display("FAIL rst_async got req=%b stall=%b want 0/0", dmem.dmem_req, stall); end
    #2 rst_n = 1'b1;
    tick();
    n_cmp++; if (dmem.dmem_req !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL rst_idle got req=%b done=%b want 0/0", dmem.dmem_req, done); end
    test_lb(1'b0, 32'h101, 32'h0000_7F00, 4'b0010, 32'h0000_007F);
  endtask

`ifdef MEM_ACCESS_TIMEOUT_EN
  task automatic test_timeout();
    int done_at;
    done_at = -1;
    issue(2'b00, 1'b0, 1'b0, 32'h400, 32'h0);
    dmem.dmem_ready_n = 1'b1;
    tick(); start = 1'b0;
    // Cycle N+1 is the first WAIT cycle; four WAIT cycles put done at N+5.
    for (int c = 1; c <= 8 && done_at < 0; c++) begin
      if (done) begin
        done_at = c;
        n_cmp++; if (bus_error !== 1'b1 || load_data !== 32'h0) begin n_bad++; $display("FAIL to_flags got berr=%b ld=%h want 1/0", bus_error, load_data); end
      end
      tick();
    end
    n_cmp++; if (done_at != 5) begin n_bad++; $display("FAIL to_latency got N+%0d want N+5", done_at); end
  endtask
`endif

  initial begin
    dmem.dmem_rdata = '0;
    dmem.dmem_ready_n = 1'b1;
    #12;
    test_reset();
    rst_n = 1'b1;
    tick();
    test_lb(1'b0, 32'h103, 32'h80FF_0000, 4'b1000, 32'hFFFF_FF80);
    test_lb(1'b1, 32'h103, 32'h80FF_0000, 4'b1000, 32'h0000_0080);
    test_sh();
    test_lw_wait();
    test_misaligned();
    test_reset_mid_wait();
`ifdef MEM_ACCESS_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Data-memory access sequencer sitting directly downstream of `mem_ctrl` in the MEM stage. Consumes `access_size` / `write_to_data_mem` / `require_mem_access` plus address and store data, runs the request/ready handshake with the data memory, and steers byte lanes. Returns aligned, sign- or zero-extended load data to writeback and holds the pipeline via `stall` until the access completes.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 16: WAIT cycles before abort. Used only with `MEM_ACCESS_TIMEOUT_EN`; minimum 1.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  `require_mem_access` from `mem_ctrl`; sampled only in IDLE
- `access_size`  in  2  00 word, 01 half, 10 byte, 11 no access
- `write_to_data_mem`  in  1  1 store, 0 load
- `load_unsigned`  in  1  funct3[2]; 1 = LBU/LHU zero-extend
- `addr`  in  32  byte address
- `store_data`  in  32  rs2 value
- `dmem_req`  out  1  bus request, high for whole WAIT state
- `dmem_we`  out  1  write strobe, valid with `dmem_req`
- `dmem_addr`  out  32  `{addr[31:2],2'b00}`, registered
- `dmem_be`  out  4  byte enables, registered
- `dmem_wdata`  out  32  lane-replicated store data, registered
- `dmem_rdata`  in  32  read word, valid when `dmem_ready_n`=0
- `dmem_ready_n`  in  1  active-low completion from memory
- `load_data`  out  32  extended load result
- `done`  out  1  one-cycle completion pulse
- `stall`  out  1  pipeline hold
- `misaligned`  out  1  one-cycle pulse with `done` on misaligned request
- `bus_error`  out  1  one-cycle pulse with `done` on timeout (tied 0 without macro)

## Operation
- FSM: IDLE, WAIT, DONE.
- IDLE: `start`=1 and `access_size`≠11 → check alignment. Aligned → register addr/be/wdata/we/size/unsigned, go WAIT. Misaligned (half with addr[0]=1, word with addr[1:0]≠0) → go DONE with `misaligned` flagged, no bus request. `access_size`=11 → stay IDLE.
- WAIT: `dmem_req`=1. `dmem_ready_n`=0 → capture `dmem_rdata` (loads only), go DONE.
- DONE: `done`=1 for one cycle, then IDLE. `start` is not sampled in DONE.
- Byte enables (little-endian): byte → 0001 shifted by addr[1:0]; half → 0011 shifted by {addr[1],0}; word → 1111.
- Store data: byte → `{4{store_data[7:0]}}`; half → `{2{store_data[15:0]}}`; word → unchanged.
- Load: select lane by registered addr[1:0], sign-extend unless `load_unsigned`. Word loads ignore `load_unsigned`. Stores leave `load_data` unchanged.
- `load_data` is registered, updates on the DONE transition, holds until the next load. Misaligned and timed-out loads set it to 0.

## Timing
- Reset (async, immediate): state IDLE; `dmem_req`, `dmem_we`, `done`, `misaligned`, `bus_error`, `stall`=0; `dmem_addr`, `dmem_be`, `dmem_wdata`, `load_data`=0.
- Reset during WAIT drops `dmem_req` the same instant. The in-flight access is abandoned.
- `stall` is combinational: 1 when (IDLE && `start` && `access_size`≠11) or state=WAIT. It is 0 in DONE, so the pipeline advances on the `done` cycle.
- Minimum latency: `start` cycle N → `dmem_req` cycle N+1 → ready_n=0 in N+1 → `done` cycle N+2.
- Misaligned: `start` cycle N → `done` and `misaligned` cycle N+1.
- Inputs other than `dmem_*` matter only in the IDLE sampling cycle.

## Configuration
- `MEM_ACCESS_TIMEOUT_EN` defined:
  - A WAIT-cycle counter is compiled in; it is cleared on entry to WAIT.
  - When the counter reaches `TIMEOUT_CYCLES` with `dmem_ready_n` still 1: go DONE with `bus_error`=1 and `load_data`=0.
  - If ready_n=0 arrives on the same cycle as the timeout, the access completes normally with no error.
- Undefined: no counter; WAIT lasts indefinitely; `bus_error` is constant 0.

## Test plan
- LB from addr 0x103, rdata 0x80FF_0000, ready_n low on first WAIT cycle → `dmem_be`=1000, `done` at N+2, `load_data`=0xFFFF_FF80. Repeat as LBU → 0x0000_0080.
- SH to 0x202, store_data 0x1234_ABCD → `dmem_addr`=0x200, `dmem_be`=1100, `dmem_wdata`=0xABCD_ABCD, `dmem_we`=1, `load_data` unchanged.
- LW with ready_n held high 5 cycles → `stall`=1 for 6 cycles, `dmem_req` held, `done` on the cycle after ready_n falls, `load_data`=rdata.
- LW at 0x102 → no `dmem_req`, `misaligned`=`done`=1 at N+1, `load_data`=0.
- `rst_n` pulsed low mid-WAIT → `dmem_req`/`stall` 0 immediately, IDLE after release, next LB completes normally.
- With `MEM_ACCESS_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, ready_n stuck high → `bus_error`=`done`=1 after 4 WAIT cycles, `load_data`=0.
